// File: rtl/_blit_rdata_capture.sv
// _blit_rdata_capture: one-outstanding blitter read capture into srcd/srcz/dstd/dstz with source realignment.
module _blit_rdata_capture #(parameter int TIMEOUT_CYC = 255) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [1:0]  rd_type,
  input  logic [63:0] rdata_in,
  input  logic        rdata_ack,
  input  logic [5:0]  srcshift,
  input  logic        srcd_flush,
  output logic        rd_busy,
  output logic        load_done,
  output logic [31:0] srcd_lo,
  output logic [31:0] srcd_hi,
  output logic [31:0] srcz_lo,
  output logic [31:0] srcz_hi,
  output logic [31:0] dstd_lo,
  output logic [31:0] dstd_hi,
  output logic [31:0] dstz_lo,
  output logic [31:0] dstz_hi,
  output logic        rd_tmo
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state;
  logic [1:0]  type_q;
  logic [63:0] srcd_raw, srcd_prev, srcz, dstd, dstz;
  logic        expire;
`ifdef RDCAP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic          tmo_q;
  assign expire = cnt == CW'(TIMEOUT_CYC - 1);
  assign rd_tmo = tmo_q;
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt   <= state == WAIT ? cnt + 1'b1 : '0;
      tmo_q <= tmo_q | (state == WAIT && !rdata_ack && expire);
    end
`else
  assign expire = 1'b0;
  assign rd_tmo = 1'b0;
`endif
  assign rd_busy            = state == WAIT;
  assign {srcd_hi, srcd_lo} = 64'({srcd_raw, srcd_prev} >> srcshift);
  assign {srcz_hi, srcz_lo} = srcz;
  assign {dstd_hi, dstd_lo} = dstd;
  assign {dstz_hi, dstz_lo} = dstz;
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      type_q    <= 2'd0;
      load_done <= 1'b0;
      srcd_raw  <= '0;
      srcd_prev <= '0;
      srcz      <= '0;
      dstd      <= '0;
      dstz      <= '0;
    end else begin
      load_done <= 1'b0;
      if (state == IDLE) begin
        if (srcd_flush) begin
          srcd_raw  <= '0;
          srcd_prev <= '0;
        end
        if (rd_req) begin
          type_q <= rd_type;
          state  <= WAIT;
        end
      end else if (rdata_ack) begin
        state     <= IDLE;
        load_done <= 1'b1;
        case (type_q)
          2'd0: begin
            srcd_prev <= srcd_raw;
            srcd_raw  <= rdata_in;
          end
          2'd1:    srcz <= rdata_in;
          2'd2:    dstd <= rdata_in;
          default: dstz <= rdata_in;
        endcase
      end else if (expire) begin
        state <= IDLE;
      end
    end
endmodule
